uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing with a one-entry holding buffer so that frames can be sent
// back to back. Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
`timescale 1ns/1ps

module uart_tx #(
    parameter int unsigned clk_freq  = 27000000,
    parameter int unsigned baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_tx,
    input  logic       send,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int unsigned div_counter = clk_freq / baud_rate;
    localparam int unsigned cnt_w       = (div_counter > 1) ? $clog2(div_counter) : 1;
    localparam logic [cnt_w-1:0] cnt_max = cnt_w'(div_counter - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
`ifdef UART_TX_PARITY_EN
        StParity = 3'd4,
`endif
        StStop   = 3'd3
    } state_e;

    state_e           state_q, state_d;
    logic [cnt_w-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             ready_q, ready_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic       accept;
    logic       drain;
    logic       bit_end;
    logic [2:0] next_bit;

    assign accept   = send && ready_q;
    assign bit_end  = (baud_cnt_q == cnt_max);
    assign next_bit = bit_cnt_q + 3'd1;

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = bit_end ? '0 : baud_cnt_q + cnt_w'(1);
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        drain      = 1'b0;

        case (state_q)
            StIdle: begin
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
                if (buf_full_q) begin
                    drain   = 1'b1;
                    state_d = StStart;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
                        tx_d    = ^shift_q;
`else
                        state_d = StStop;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_cnt_d = next_bit;
                        tx_d      = shift_q[next_bit];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    tx_d    = 1'b1;
                end
            end
`endif
            StStop: begin
                if (bit_end) begin
                    done_d = 1'b1;
                    // A queued byte starts immediately so the line never idles between frames.
                    if (buf_full_q) begin
                        drain   = 1'b1;
                        state_d = StStart;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = StIdle;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                baud_cnt_d = '0;
                bit_cnt_d  = '0;
                tx_d       = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_comb begin
        shift_d    = drain ? buf_q : shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        if (drain) begin
            buf_full_d = 1'b0;
        end
        if (accept) begin
            buf_full_d = 1'b1;
            buf_d      = data_tx;
        end
        ready_d = !buf_full_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            ready_q    <= 1'b1;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            ready_q    <= ready_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign ready = ready_q;
    assign tx    = tx_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule
